// File: rtl/contagem_pkg.sv
// contagem_pkg: shared state type and byte/popcount widths for the frame ones-counter
package contagem_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;
    localparam int BYTE_W = 8;
    localparam int POP_W  = 4;
endpackage

// File: rtl/controlador_contagem_uns_popcount.sv
// controlador_contagem_uns_popcount: combinational count of set bits in one byte
module controlador_contagem_uns_popcount
    import contagem_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic [POP_W-1:0]  count
);
    // Sum every bit of the byte into a 4-bit total (max 8)
    always_comb begin
        count = '0;
        for (int i = 0; i < BYTE_W; i++) count = count + POP_W'(data[i]);
    end
endmodule

// File: rtl/controlador_contagem_uns.sv
// controlador_contagem_uns: frame sequencer accumulating byte popcounts into a handshaked result
module controlador_contagem_uns
    import contagem_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = LEN_W + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              abort,
    output logic              busy,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_count,
    input  logic              out_ready
);
    estado_t          state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] acc_q, acc_d, cnt_q, cnt_d, sum;
    logic             busy_q, busy_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [POP_W-1:0] pop;
    logic             beat;

    controlador_contagem_uns_popcount u_pop (
        .data  (in_data),
        .count (pop)
    );

    // in_ready is registered high exactly while in RUN, so it doubles as the state qualifier
    assign beat = in_valid && in_ready_q;
    assign sum  = acc_q + ACC_W'(pop);

    // Next-state and datapath updates; abort wins over beats, start and the result handshake
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d = (frame_len != '0) ? RUN : DONE;
                rem_d   = frame_len;
                acc_d   = '0;
                cnt_d   = '0;
            end
            RUN: if (abort) begin
                state_d = IDLE;
                acc_d   = '0;
            end else if (beat) begin
                acc_d = sum;
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = sum;
                end
            end
            DONE: if (abort) begin
                state_d = IDLE;
                acc_d   = '0;
            end else if (out_ready) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d      = state_d != IDLE;
        in_ready_d  = state_d == RUN;
        out_valid_d = state_d == DONE;
    end

    // State, counters and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = cnt_q;
endmodule

// File: tb/tb_controlador_contagem_uns.sv
// tb_controlador_contagem_uns: table, directed and randomized checks of the frame ones-counter
module tb_controlador_contagem_uns;
    logic clk = 0, rst_n = 1, start = 0, abort = 0, in_valid = 0, out_ready = 0;
    logic [7:0] frame_len = 0, in_data = 0;
    logic busy, in_ready, out_valid;
    logic [11:0] out_count;
    int total = 0, bad = 0;
    logic [7:0] fb [0:255];
    bit noise = 0;

    typedef struct { int len; logic [31:0] bytes; int exp; } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    controlador_contagem_uns dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .abort(abort),
        .busy(busy), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_count(out_count), .out_ready(out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input int len, input int gap, input int exp);
        int beats = 0;
        int n = 0;
        bit took;
        start = 1; frame_len = 8'(len);
        step();
        start = 0;
        chk({name, "_busy"}, busy, 1);
        if (len == 0) chk({name, "_in_ready"}, in_ready, 0);
        while (!out_valid && n < 3000) begin
            in_valid = (beats < len) && ($urandom_range(99) >= gap);
            in_data = in_valid ? fb[beats] : 8'($urandom);
            if (noise) begin
                start = 1'($urandom_range(1));
                frame_len = 8'($urandom);
            end
            took = in_valid && in_ready;
            step();
            n++;
            if (took) begin
                beats++;
                if (beats == len) chk({name, "_latency"}, out_valid, 1);
            end
        end
        in_valid = 0; start = 0;
        chk({name, "_done"}, out_valid, 1);
        chk({name, "_beats"}, beats, len);
        chk({name, "_count"}, out_count, exp);
    endtask

    task automatic take(input string name);
        out_ready = 1;
        step();
        out_ready = 0;
        chk({name, "_ov_clr"}, out_valid, 0);
        chk({name, "_idle"}, busy, 0);
        step();
    endtask

    initial begin
        int exp, len;
        logic [31:0] b;
        tbl = '{'{3, 32'h0081_00FF, 10}, '{0, 32'h0, 0}, '{1, 32'h0000_000F, 4},
                '{4, 32'h0804_0201, 4}, '{2, 32'h0000_55AA, 8}, '{4, 32'hFFFF_FFFF, 32},
                '{4, 32'h7F3C_1080, 13}};
        #1 rst_n = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        #10 rst_n = 1;
        step();

        for (int i = 0; i < 7; i++) begin
            b = tbl[i].bytes;
            for (int j = 0; j < 4; j++) fb[j] = b[j*8 +: 8];
            run_frame($sformatf("tbl%0d", i), tbl[i].len, 0, tbl[i].exp);
            take($sformatf("tbl%0d", i));
        end

        for (int j = 0; j < 256; j++) fb[j] = 8'hFF;
        run_frame("len255", 255, 30, 2040);
        take("len255");

        noise = 1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 40);
            exp = 0;
            for (int j = 0; j < len; j++) begin
                fb[j] = 8'($urandom);
                exp += $countones(fb[j]);
            end
            run_frame($sformatf("rnd%0d", f), len, $urandom_range(0, 50), exp);
            take($sformatf("rnd%0d", f));
        end
        noise = 0;

        start = 1; frame_len = 4;
        step();
        start = 0;
        for (int j = 0; j < 2; j++) begin
            in_valid = 1; in_data = 8'hFF;
            step();
        end
        abort = 1;
        step();
        abort = 0; in_valid = 0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_ov", out_valid, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("abort_quiet", out_valid, 0);
        end
        fb[0] = 8'h0F;
        run_frame("after_abort", 1, 0, 4);
        take("after_abort");

        abort = 1; start = 1; frame_len = 3;
        step();
        abort = 0; start = 0;
        chk("idle_abort_start", busy, 0);
        step();

        fb[0] = 8'h01;
        run_frame("done_abort", 1, 0, 1);
        abort = 1;
        step();
        abort = 0;
        chk("done_abort_ov", out_valid, 0);
        chk("done_abort_busy", busy, 0);
        step();

        fb[0] = 8'hF0; fb[1] = 8'h33;
        run_frame("hold", 2, 0, 8);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin start = 1; frame_len = 7; end
            step();
            start = 0;
            chk("hold_ov", out_valid, 1);
            chk("hold_cnt", out_count, 8);
        end
        take("hold");

        out_ready = 1; start = 1; frame_len = 1;
        step();
        start = 0; in_valid = 1; in_data = 8'h07;
        step();
        in_valid = 0;
        chk("early_ready_ov", out_valid, 1);
        chk("early_ready_cnt", out_count, 3);
        step();
        chk("early_ready_one_cycle", out_valid, 0);
        out_ready = 0;
        step();

        start = 1; frame_len = 5;
        step();
        start = 0;
        for (int j = 0; j < 2; j++) begin
            in_valid = 1; in_data = 8'hFF;
            step();
        end
        #3 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_count", out_count, 0);
        in_valid = 0;
        #2 rst_n = 1;
        step();
        chk("arst_idle", busy, 0);
        fb[0] = 8'h11; fb[1] = 8'hE0; fb[2] = 8'h0B;
        run_frame("post_rst", 3, 20, 8);
        take("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
